// File: rtl/mdu_seq.sv
// mdu_seq : sequential multiply/divide unit for the EX stage.
//
// Runs a radix-2 restoring divide (div/divu) over 32 cycles. It holds the
// pipeline with stallreq from the accept cycle until the last iteration,
// then pulses res_valid for one cycle with the result on hi_out/lo_out.
// Signed operations run on magnitudes and fix up the signs at the end.
//
// Optional feature: macro MDU_ITER_MUL_EN.
//   Defined   : mult/multu run through the same FSM as a 32-cycle
//               shift-add and have the same timing as a divide.
//   Undefined : mult/multu are answered combinationally in the accept
//               cycle, with no stall. The product is also registered so
//               that hi_out/lo_out keep holding it afterwards.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   op_valid    EX stage holds a mul/div instruction
//   op_type     00 div, 01 divu, 10 mult, 11 multu
//   src_a       dividend / multiplicand
//   src_b       divisor / multiplier
//   stallreq    stall request to the pipeline control
//   res_valid   hi_out/lo_out carry a fresh result this cycle
//   hi_out      remainder (div) / product[63:32] (mult)
//   lo_out      quotient (div) / product[31:0] (mult)
//   div_by_zero last completed divide had a zero divisor
//   busy        FSM is not in IDLE
module mdu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        res_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_by_zero,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic        op_mul_q;
  logic        neg_lo_q;
  logic        neg_hi_q;
  logic        dz_flag_q;
  logic        dz_q;
  logic [31:0] opnd_q;
  logic [31:0] work_hi;
  logic [31:0] work_lo;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        accept;
  logic        iter_op;
  logic        start;
  logic        comb_mul;
  logic        done_act;
  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] prod_comb;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] div_hi_nx;
  logic [31:0] div_lo_nx;
  logic [32:0] sum;
  logic [31:0] mul_hi_nx;
  logic [31:0] mul_lo_nx;

  logic [63:0] prod_iter;
  logic [63:0] prod_signed;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

  assign accept    = (state == IDLE) && op_valid && !rst;
  assign signed_op = ~op_type[0];
  assign mag_a     = (signed_op && src_a[31]) ? -src_a : src_a;
  assign mag_b     = (signed_op && src_b[31]) ? -src_b : src_b;

`ifdef MDU_ITER_MUL_EN
  assign iter_op   = 1'b1;
  assign comb_mul  = 1'b0;
  assign prod_comb = '0;
`else
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  assign iter_op   = ~op_type[1];
  assign comb_mul  = accept & op_type[1];
  assign ext_a     = op_type[0] ? {32'b0, src_a} : {{32{src_a[31]}}, src_a};
  assign ext_b     = op_type[0] ? {32'b0, src_b} : {{32{src_b[31]}}, src_b};
  assign prod_comb = ext_a * ext_b;
`endif

  assign start = accept & iter_op;

  // Restoring divide step. The remainder is always below the divisor, so
  // bit 32 of the trial subtraction is set exactly when the shifted
  // remainder is smaller than the divisor.
  assign rem_sh    = {work_hi, work_lo[31]};
  assign diff      = rem_sh - {1'b0, opnd_q};
  assign ge        = ~diff[32];
  assign div_hi_nx = ge ? diff[31:0] : rem_sh[31:0];
  assign div_lo_nx = {work_lo[30:0], ge};

  // Shift-add multiply step. The multiplier is shifted out of work_lo
  // while product bits are shifted in from the top.
  assign sum       = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_hi_nx = sum[32:1];
  assign mul_lo_nx = {sum[0], work_lo[31:1]};

  // Sign fix-up of the finished magnitude result. A zero-divisor divide
  // passes its preloaded values through untouched.
  assign prod_iter   = {work_hi, work_lo};
  assign prod_signed = neg_lo_q ? -prod_iter : prod_iter;

  always_comb begin
    fin_hi = prod_signed[63:32];
    fin_lo = prod_signed[31:0];
    if (!op_mul_q) begin
      if (dz_flag_q) begin
        fin_hi = work_hi;
        fin_lo = work_lo;
      end else begin
        fin_lo = neg_lo_q ? -work_lo : work_lo;
        fin_hi = neg_hi_q ? -work_hi : work_hi;
      end
    end
  end

  assign done_act    = (state == DONE) && !rst;
  assign res_valid   = done_act | comb_mul;
  assign stallreq    = start | ((state == BUSY) && !rst);
  assign busy        = (state != IDLE);
  assign hi_out      = done_act ? fin_hi : (comb_mul ? prod_comb[63:32] : hi_q);
  assign lo_out      = done_act ? fin_lo : (comb_mul ? prod_comb[31:0]  : lo_q);
  assign div_by_zero = (done_act && !op_mul_q) ? dz_flag_q : dz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_mul_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_flag_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            op_mul_q  <= op_type[1];
            neg_lo_q  <= signed_op & (src_a[31] ^ src_b[31]);
            neg_hi_q  <= signed_op & src_a[31];
            work_hi   <= '0;
            dz_flag_q <= 1'b0;
            if (op_type[1]) begin
              opnd_q  <= mag_a;
              work_lo <= mag_b;
              state   <= BUSY;
            end else if (src_b == 32'd0) begin
              // A zero divisor skips the iterations and finishes next cycle.
              opnd_q    <= src_b;
              work_hi   <= src_a;
              work_lo   <= '1;
              dz_flag_q <= 1'b1;
              state     <= DONE;
            end else begin
              opnd_q  <= mag_b;
              work_lo <= mag_a;
              state   <= BUSY;
            end
          end else if (comb_mul) begin
            hi_q <= prod_comb[63:32];
            lo_q <= prod_comb[31:0];
          end
        end
        BUSY: begin
          cnt     <= cnt + 6'd1;
          work_hi <= op_mul_q ? mul_hi_nx : div_hi_nx;
          work_lo <= op_mul_q ? mul_lo_nx : div_lo_nx;
          if (cnt == 6'd31) state <= DONE;
        end
        DONE: begin
          hi_q <= fin_hi;
          lo_q <= fin_lo;
          if (!op_mul_q) dz_q <= dz_flag_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq : directed self-checking bench for mdu_seq.
// Each operation is checked for result latency, the number of stall cycles,
// the result values, div_by_zero and busy. It also checks that the result
// is still held one cycle after the res_valid pulse. Expected mult timing
// follows MDU_ITER_MUL_EN when the bench is built with that macro.
module tb_mdu_seq;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stallreq;
  logic        res_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_by_zero;
  logic        busy;

  int checkCount = 0;
  int errorCount = 0;

`ifdef MDU_ITER_MUL_EN
  localparam int MUL_LAT   = 33;
  localparam int MUL_STALL = 33;
  localparam logic MUL_BUSY = 1'b1;
`else
  localparam int MUL_LAT   = 0;
  localparam int MUL_STALL = 0;
  localparam logic MUL_BUSY = 1'b0;
`endif

  mdu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_type    (op_type),
    .src_a      (src_a),
    .src_b      (src_b),
    .stallreq   (stallreq),
    .res_valid  (res_valid),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one operation in the current cycle (called just after a rising
  // edge), then drops op_valid and follows it until res_valid.
  task automatic applyStimulus(input string tag, input logic [1:0] t,
                               input logic [31:0] a, input logic [31:0] b,
                               input int expLat, input int expStall,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input logic expDz, input logic expBusy);
    int          lat;
    int          stalls;
    bit          got;
    logic [31:0] hiCap;
    logic [31:0] loCap;
    logic        dzCap;
    logic        busyCap;
    op_type  = t;
    src_a    = a;
    src_b    = b;
    op_valid = 1'b1;
    lat = -1; stalls = 0; got = 0;
    hiCap = '0; loCap = '0; dzCap = 1'b0; busyCap = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (stallreq) stalls++;
      if (res_valid) begin
        got = 1; lat = c;
        hiCap = hi_out; loCap = lo_out; dzCap = div_by_zero; busyCap = busy;
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, ".stalls"}, 64'(stalls), 64'(expStall));
    checkOutput({tag, ".hi"}, {32'b0, hiCap}, {32'b0, expHi});
    checkOutput({tag, ".lo"}, {32'b0, loCap}, {32'b0, expLo});
    checkOutput({tag, ".dz"}, {63'b0, dzCap}, {63'b0, expDz});
    checkOutput({tag, ".busy"}, {63'b0, busyCap}, {63'b0, expBusy});
    #1;
    checkOutput({tag, ".pulse_end"}, {63'b0, res_valid}, 64'd0);
    checkOutput({tag, ".hold_hi"}, {32'b0, hi_out}, {32'b0, expHi});
    checkOutput({tag, ".hold_lo"}, {32'b0, lo_out}, {32'b0, expLo});
  endtask

  initial begin
    int pulses;
    int busyCycles;
    rst = 1'b1; op_valid = 1'b1; op_type = 2'b01; src_a = 32'd100; src_b = 32'd7;
    #2;
    checkOutput("reset.stallreq", {63'b0, stallreq}, 64'd0);
    checkOutput("reset.res_valid", {63'b0, res_valid}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset.hi", {32'b0, hi_out}, 64'd0);
    checkOutput("reset.lo", {32'b0, lo_out}, 64'd0);
    checkOutput("reset.busy", {63'b0, busy}, 64'd0);
    checkOutput("reset.dz", {63'b0, div_by_zero}, 64'd0);
    op_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7, 33, 33, 32'd2, 32'd14, 1'b0, 1'b1);
    applyStimulus("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 33, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
    applyStimulus("div_7_m2", 2'b00, 32'd7, 32'hFFFFFFFE, 33, 33, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b1);
    applyStimulus("div_min_m1", 2'b00, 32'h80000000, 32'hFFFFFFFF, 33, 33, 32'd0, 32'h80000000, 1'b0, 1'b1);
    applyStimulus("div_5_0", 2'b00, 32'd5, 32'd0, 1, 1, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b1);
    checkOutput("div_5_0.dz_hold", {63'b0, div_by_zero}, 64'd1);
    applyStimulus("mult_m3_4", 2'b10, 32'hFFFFFFFD, 32'd4, MUL_LAT, MUL_STALL, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b1, MUL_BUSY);
    applyStimulus("multu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, MUL_STALL, 32'hFFFFFFFE, 32'h00000001, 1'b1, MUL_BUSY);
    // Back-to-back: the second op is presented in the cycle right after DONE.
    applyStimulus("divu_9_3", 2'b01, 32'd9, 32'd3, 33, 33, 32'd0, 32'd3, 1'b0, 1'b1);
    applyStimulus("divu_8_3", 2'b01, 32'd8, 32'd3, 33, 33, 32'd2, 32'd2, 1'b0, 1'b1);
    applyStimulus("div_0_0", 2'b00, 32'd0, 32'd0, 1, 1, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1);

    // Reset in the middle of a divide: cycle T is now.
    op_type = 2'b01; src_a = 32'd1000; src_b = 32'd3; op_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    checkOutput("rst_mid.stall_during", {63'b0, stallreq}, 64'd0);
    checkOutput("rst_mid.valid_during", {63'b0, res_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_mid.busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_mid.stallreq", {63'b0, stallreq}, 64'd0);
    checkOutput("rst_mid.hi", {32'b0, hi_out}, 64'd0);
    checkOutput("rst_mid.lo", {32'b0, lo_out}, 64'd0);
    checkOutput("rst_mid.dz", {63'b0, div_by_zero}, 64'd0);
    pulses = 0; busyCycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (res_valid) pulses++;
      if (busy) busyCycles++;
    end
    checkOutput("rst_mid.no_valid", 64'(pulses), 64'd0);
    checkOutput("rst_mid.stays_idle", 64'(busyCycles), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
